// File: rtl/noc_pkg.sv
// Shared NoC router definitions: port indices, arbiter states, fixed-point scale.
package noc_pkg;

   localparam int PORT_N      = 0;
   localparam int PORT_S      = 1;
   localparam int PORT_E      = 2;
   localparam int PORT_W      = 3;
   localparam int PORT_L      = 4;
   localparam int NUM_PORTS   = 5;

   localparam int MILLI_SCALE = 1000;

   typedef enum logic {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

endpackage

// File: rtl/noc_rr_pick.sv
// Rotating-priority picker: first set request strictly after ptr, wrapping.
module noc_rr_pick #(
   parameter int N  = 5,
   parameter int IW = 3
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  onehot,
   output logic [IW-1:0] idx,
   output logic          any
);

   // Scan offsets 1..N from the pointer; the pointer itself is checked last.
   always_comb begin
      int j;
      onehot = '0;
      idx    = '0;
      any    = 1'b0;
      j      = 0;
      for (int off = 1; off <= N; off++) begin
         j = int'(ptr) + off;
         if (j >= N) j = j - N;
         if (!any && req[j]) begin
            any       = 1'b1;
            onehot[j] = 1'b1;
            idx       = IW'(j);
         end
      end
   end

endmodule

// File: rtl/noc_output_arbiter.sv
// Output-port arbiter for one NoC router port: round-robin between inputs,
// wormhole lock for multi-flit packets, registered output stage, and
// stall/grant/congestion statistics.
//
// state  | meaning
// ARB    | no packet in flight; round-robin pick among valid inputs
// LOCKED | a packet's head was sent without its tail; only owner may send
module noc_output_arbiter
   import noc_pkg::*;
#(
   parameter int NUM_IN      = NUM_PORTS,
   parameter int FLIT_WIDTH  = 64,
   parameter int WINDOW_LOG2 = 7,
   parameter int CNT_W       = 32
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_IN-1:0]            req_valid,
   input  logic [NUM_IN*FLIT_WIDTH-1:0] req_flit,
   input  logic [NUM_IN-1:0]            req_tail,
   output logic [NUM_IN-1:0]            req_ready,
   output logic [FLIT_WIDTH-1:0]        out_flit,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [NUM_IN-1:0]            grant_onehot,
   output logic                         locked,
   output logic [NUM_IN*CNT_W-1:0]      stall_count,
   output logic [CNT_W-1:0]             grants_total,
   output logic [15:0]                  congestion_milli
);

   localparam int IW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
   localparam int PW = WINDOW_LOG2 + 11;

   arb_state_e              state, state_n;
   logic [IW-1:0]           owner, owner_n;
   logic [IW-1:0]           rr_ptr, rr_n;
   logic [NUM_IN-1:0]       pick_onehot;
   logic [IW-1:0]           pick_idx;
   logic                    pick_any;
   logic                    load_en;
   logic                    xfer;
   logic [IW-1:0]           win_idx;
   logic [FLIT_WIDTH-1:0]   win_flit;
   logic                    win_tail;
   logic [NUM_IN-1:0]       stall_vec;
   logic                    any_stall;
   logic [CNT_W-1:0]        stall_cnt [NUM_IN];
   logic [WINDOW_LOG2-1:0]  win_cnt;
   logic [WINDOW_LOG2:0]    stall_cycles;
   logic [WINDOW_LOG2:0]    stall_sum;
   logic [PW-1:0]           milli_prod;

   noc_rr_pick #(.N(NUM_IN), .IW(IW)) u_pick (
      .req    (req_valid),
      .ptr    (rr_ptr),
      .onehot (pick_onehot),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   assign load_en      = !out_valid || out_ready;
   assign locked       = (state == LOCKED);
   assign grant_onehot = req_valid & req_ready;
   assign xfer         = |grant_onehot;
   assign stall_vec    = req_valid & ~req_ready;
   assign any_stall    = |stall_vec;
   assign win_flit     = req_flit[int'(win_idx)*FLIT_WIDTH +: FLIT_WIDTH];
   assign win_tail     = req_tail[win_idx];

   // Ready is withheld entirely while reset is low or the output stage is full.
   always_comb begin
      req_ready = '0;
      win_idx   = pick_idx;
      if (state == LOCKED) win_idx = owner;
      if (reset && load_en) begin
         if (state == ARB) req_ready = pick_onehot;
         else              req_ready[owner] = 1'b1;
      end
   end

   // Lock on a non-tail transfer, release and advance the pointer on a tail.
   always_comb begin
      state_n = state;
      owner_n = owner;
      rr_n    = rr_ptr;
      if (xfer) begin
         if (win_tail) begin
            state_n = ARB;
            rr_n    = win_idx;
         end else begin
            state_n = LOCKED;
            owner_n = win_idx;
         end
      end
   end

   // Arbitration state register; pointer resets so input 0 is scanned first.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= ARB;
         owner  <= '0;
         rr_ptr <= IW'(NUM_IN - 1);
      end else begin
         state  <= state_n;
         owner  <= owner_n;
         rr_ptr <= rr_n;
      end
   end

   // Output register: load on free slot, hold while downstream backpressures.
   always_ff @(posedge clk) begin
      if (!reset) begin
         out_valid <= 1'b0;
         out_flit  <= '0;
      end else if (load_en) begin
         out_valid <= xfer;
         if (xfer) out_flit <= win_flit;
      end
   end

   // Saturating per-input stall counters and total grant counter.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < NUM_IN; i++) stall_cnt[i] <= '0;
         grants_total <= '0;
      end else begin
         for (int i = 0; i < NUM_IN; i++)
            if (stall_vec[i] && (stall_cnt[i] != '1)) stall_cnt[i] <= stall_cnt[i] + 1'b1;
         if (xfer && (grants_total != '1)) grants_total <= grants_total + 1'b1;
      end
   end

   for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_stall
      assign stall_count[gi*CNT_W +: CNT_W] = stall_cnt[gi];
   end

   // Fold the current cycle in, since the window closes on this edge.
   always_comb begin
      stall_sum  = stall_cycles + (WINDOW_LOG2+1)'(any_stall);
      milli_prod = PW'(stall_sum) * PW'(MILLI_SCALE);
   end

   // Congestion window: count stalled cycles, publish the fraction at wrap.
   always_ff @(posedge clk) begin
      if (!reset) begin
         win_cnt          <= '0;
         stall_cycles     <= '0;
         congestion_milli <= '0;
      end else begin
         win_cnt <= win_cnt + 1'b1;
         if (&win_cnt) begin
            stall_cycles     <= '0;
            congestion_milli <= 16'(milli_prod >> WINDOW_LOG2);
         end else begin
            stall_cycles <= stall_sum;
         end
      end
   end

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Directed bench for noc_output_arbiter with hand-computed expectations.
module tb_noc_output_arbiter;

   localparam int N  = 5;
   localparam int FW = 64;
   localparam int CW = 32;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    req_valid;
   logic [N*FW-1:0] req_flit;
   logic [N-1:0]    req_tail;
   logic [N-1:0]    req_ready;
   logic [FW-1:0]   out_flit;
   logic            out_valid;
   logic            out_ready;
   logic [N-1:0]    grant_onehot;
   logic            locked;
   logic [N*CW-1:0] stall_count;
   logic [CW-1:0]   grants_total;
   logic [15:0]     congestion_milli;

   int pass_cnt  = 0;
   int total_cnt = 0;

   noc_output_arbiter #(
      .NUM_IN(N), .FLIT_WIDTH(FW), .WINDOW_LOG2(7), .CNT_W(CW)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .req_valid        (req_valid),
      .req_flit         (req_flit),
      .req_tail         (req_tail),
      .req_ready        (req_ready),
      .out_flit         (out_flit),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .grant_onehot     (grant_onehot),
      .locked           (locked),
      .stall_count      (stall_count),
      .grants_total     (grants_total),
      .congestion_milli (congestion_milli)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_flit(input int i, input logic [FW-1:0] v);
      req_flit[i*FW +: FW] = v;
   endtask

   function automatic logic [CW-1:0] stall_of(input int i);
      return stall_count[i*CW +: CW];
   endfunction

   task automatic do_reset();
      reset     = 1'b0;
      req_valid = '0;
      req_tail  = '1;
      out_ready = 1'b1;
      tick();
      tick();
      reset = 1'b1;
   endtask

   initial begin
      reset     = 1'b0;
      req_valid = '1;
      req_flit  = '0;
      req_tail  = '1;
      out_ready = 1'b1;
      #1;
      chk("ready_in_reset", FW'(req_ready), 64'h0);
      tick();
      chk("ready_in_reset_edge", FW'(req_ready), 64'h0);
      tick();
      chk("rst_out_valid", FW'(out_valid), 64'h0);
      chk("rst_locked", FW'(locked), 64'h0);
      chk("rst_grants", FW'(grants_total), 64'h0);
      chk("rst_cong", FW'(congestion_milli), 64'h0);
      chk("rst_stall0", FW'(stall_of(0)), 64'h0);

      // Four inputs with single-flit packets: strict rotation 0,1,2,3
      do_reset();
      for (int i = 0; i < 4; i++) set_flit(i, 64'h100 + 64'(i));
      req_valid = 5'b01111;
      req_tail  = '1;
      for (int c = 0; c < 12; c++) begin
         #1;
         chk("rr_grant", FW'(grant_onehot), 64'h1 << (c % 4));
         tick();
         chk("rr_out_flit", out_flit, 64'h100 + 64'(c % 4));
         chk("rr_out_valid", FW'(out_valid), 64'h1);
      end
      for (int i = 0; i < 4; i++) chk("rr_stall", FW'(stall_of(i)), 64'd9);
      chk("rr_stall4", FW'(stall_of(4)), 64'd0);
      chk("rr_grants", FW'(grants_total), 64'd12);
      req_valid = '0;
      tick();
      chk("idle_out_valid", FW'(out_valid), 64'h0);
      chk("idle_out_flit_hold", out_flit, 64'h103);

      // Three-flit packet from input 1 against a waiting input 0
      do_reset();
      set_flit(0, 64'hA0);
      req_valid = 5'b00001;
      req_tail  = 5'b11111;
      tick();
      chk("pkt_pre_flit", out_flit, 64'hA0);
      req_valid = 5'b00011;
      req_tail  = 5'b11101;
      set_flit(1, 64'hB1);
      #1;
      chk("pkt_g1", FW'(grant_onehot), 64'b00010);
      tick();
      chk("pkt_lock1", FW'(locked), 64'h1);
      chk("pkt_flit1", out_flit, 64'hB1);
      set_flit(1, 64'hB2);
      #1;
      chk("pkt_g2", FW'(grant_onehot), 64'b00010);
      tick();
      chk("pkt_lock2", FW'(locked), 64'h1);
      chk("pkt_flit2", out_flit, 64'hB2);
      set_flit(1, 64'hB3);
      req_tail = 5'b11111;
      #1;
      chk("pkt_g3", FW'(grant_onehot), 64'b00010);
      tick();
      chk("pkt_lock3", FW'(locked), 64'h0);
      chk("pkt_flit3", out_flit, 64'hB3);
      chk("pkt_stall0", FW'(stall_of(0)), 64'd3);
      req_valid = 5'b00001;
      #1;
      chk("pkt_after_g0", FW'(grant_onehot), 64'b00001);
      tick();
      chk("pkt_after_flit", out_flit, 64'hA0);

      // Downstream backpressure with inputs 0 and 2 waiting
      do_reset();
      set_flit(0, 64'hC0);
      set_flit(2, 64'hC2);
      req_valid = 5'b00101;
      req_tail  = '1;
      tick();
      chk("bp_first_flit", out_flit, 64'hC0);
      out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("bp_ready", FW'(req_ready), 64'h0);
         tick();
         chk("bp_flit_hold", out_flit, 64'hC0);
         chk("bp_valid_hold", FW'(out_valid), 64'h1);
      end
      chk("bp_stall0", FW'(stall_of(0)), 64'd5);
      chk("bp_stall2", FW'(stall_of(2)), 64'd6);
      out_ready = 1'b1;
      #1;
      chk("bp_release_grant", FW'(grant_onehot), 64'b00100);

      // Fully contended window then an idle window
      do_reset();
      req_valid = 5'b00011;
      req_tail  = '1;
      repeat (127) tick();
      chk("cong_before", FW'(congestion_milli), 64'd0);
      tick();
      chk("cong_full", FW'(congestion_milli), 64'd1000);
      req_valid = '0;
      repeat (127) tick();
      chk("cong_hold", FW'(congestion_milli), 64'd1000);
      tick();
      chk("cong_idle", FW'(congestion_milli), 64'd0);

      // Reset in the middle of a packet from input 3
      do_reset();
      set_flit(3, 64'hD3);
      set_flit(4, 64'hE4);
      req_valid = 5'b11000;
      req_tail  = 5'b10111;
      #1;
      chk("mid_g3", FW'(grant_onehot), 64'b01000);
      tick();
      chk("mid_locked", FW'(locked), 64'h1);
      req_valid = 5'b10000;
      #1;
      chk("mid_gap_grant", FW'(grant_onehot), 64'h0);
      chk("mid_gap_ready", FW'(req_ready), 64'b01000);
      tick();
      chk("mid_gap_locked", FW'(locked), 64'h1);
      chk("mid_gap_stall4", FW'(stall_of(4)), 64'd2);
      req_valid = 5'b11000;
      tick();
      reset = 1'b0;
      #1;
      chk("mid_rst_ready", FW'(req_ready), 64'h0);
      tick();
      reset     = 1'b1;
      req_valid = 5'b10000;
      chk("mid_rst_locked", FW'(locked), 64'h0);
      chk("mid_rst_valid", FW'(out_valid), 64'h0);
      chk("mid_rst_grants", FW'(grants_total), 64'h0);
      chk("mid_rst_stall4", FW'(stall_of(4)), 64'h0);
      #1;
      chk("mid_post_g4", FW'(grant_onehot), 64'b10000);
      tick();
      chk("mid_post_flit", out_flit, 64'hE4);
      chk("mid_post_grants", FW'(grants_total), 64'd1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/noc_output_arbiter.md
NOC_OUTPUT_ARBITER -- requirements
Module: noc_output_arbiter

Interface
REQ-001 Parameter NUM_IN, default 5, number of requesting input ports (index 0..4 = N,S,E,W,L).
REQ-002 Parameter FLIT_WIDTH, default 64, flit width in bits.
REQ-003 Parameter WINDOW_LOG2, default 7, congestion window length 2^WINDOW_LOG2 cycles.
REQ-004 Parameter CNT_W, default 32, stall/grant counter width.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 reset  input  1  synchronous, active-low reset.
REQ-007 req_valid  input  NUM_IN  per-input flit valid.
REQ-008 req_flit  input  NUM_IN*FLIT_WIDTH  per-input flit, input i at bits [i*FLIT_WIDTH +: FLIT_WIDTH].
REQ-009 req_tail  input  NUM_IN  per-input last-flit-of-packet marker.
REQ-010 req_ready  output  NUM_IN  per-input accept; transfer when req_valid[i] & req_ready[i].
REQ-011 out_flit  output  FLIT_WIDTH  registered output flit.
REQ-012 out_valid  output  1  registered output valid.
REQ-013 out_ready  input  1  downstream accept.
REQ-014 grant_onehot  output  NUM_IN  input transferring this cycle (equals req_valid & req_ready).
REQ-015 locked  output  1  high while a multi-flit packet holds the port.
REQ-016 stall_count  output  NUM_IN*CNT_W  per-input stall cycles.
REQ-017 grants_total  output  CNT_W  total accepted flits.
REQ-018 congestion_milli  output  16  stall-cycle fraction of last completed window, x1000.

Function
REQ-019 Output stage SHALL load when load_en = (!out_valid | out_ready); req_ready SHALL be zero for all inputs when load_en=0.
REQ-020 State ARB: winner = first asserted req_valid scanning from (rr_ptr+1) mod NUM_IN upward with wrap; only winner gets req_ready=1 when load_en=1.
REQ-021 State LOCKED: only lock owner eligible; others req_ready=0 regardless of valid.
REQ-022 Transfer with req_tail=0 in ARB SHALL enter LOCKED with owner=winner; transfer with req_tail=1 SHALL return to ARB and set rr_ptr=winner.
REQ-023 Single-flit transfer (tail=1) in ARB SHALL stay in ARB and set rr_ptr=winner.
REQ-024 Owner deasserting req_valid while LOCKED SHALL keep lock; no other input is granted.
REQ-025 On transfer out_flit<=winner flit, out_valid<=1 next cycle (latency 1); if load_en and no transfer, out_valid<=0; if !load_en, out_flit/out_valid hold.
REQ-026 stall_count[i] SHALL increment on every cycle with req_valid[i] & !req_ready[i], saturating at 2^CNT_W-1.
REQ-027 grants_total SHALL increment on every transfer, saturating.
REQ-028 Window counter increments every cycle, wraps at 2^WINDOW_LOG2; stall_cycles counts cycles where any input stalls.
REQ-029 On the last window cycle congestion_milli <= ((stall_cycles+this_cycle_stall)*1000)>>WINDOW_LOG2, stall_cycles cleared; max 1000.

Reset
REQ-030 reset=0 at clk edge SHALL clear out_valid, out_flit, locked/state (ARB), owner, rr_ptr=NUM_IN-1, all counters, window, congestion_milli; req_ready all 0 during reset.
REQ-031 Reset mid-packet SHALL drop the lock; first post-reset grant is to lowest-index valid input.

Structure
REQ-032 Shared package noc_pkg SHALL hold port index constants (PORT_N..PORT_L), NUM_PORTS, state enum ARB/LOCKED, milli scale 1000.
REQ-033 One sub-module noc_rr_pick (combinational rotating priority select: req vector, pointer -> one-hot, index, any).

Verification
REQ-034 Inputs 0-3 valid single-flit continuously, out_ready=1, 12 cycles -> grants 0,1,2,3 repeating; stall_count 9 each; grants_total 12.
REQ-035 Input 1 sends 3-flit packet (tail on third) while input 0 valid -> input 1 granted 3 consecutive cycles, locked=1 first two, input 0 stall +3, then input 0 granted.
REQ-036 out_valid=1, out_ready=0 for 5 cycles with inputs 0,2 valid -> req_ready=0, out_flit stable, stall_count[0] and [2] +5.
REQ-037 Contention held 128 cycles aligned to window -> congestion_milli=1000; following idle window -> 0.
REQ-038 Reset asserted mid-packet from input 3 with input 4 valid -> after release locked=0, counters 0, input 4 granted first.
